// File: rtl/biquad_log_writer.sv
// biquad_log_writer: decimates biquad output samples and writes them into the logging RAM over Wishbone.
// Define BIQUAD_LOG_PRETRIG_EN for circular pre-trigger capture; the default build is a plain post-trigger fill.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no capture; samples ignored
// S_ARMED   | waiting for trig_i (circular writes when pre-trigger enabled)
// S_CAPTURE | post-trigger writes until the buffer/post count is complete
// S_DONE    | capture finished, buffer stable for host readout
module biquad_log_writer #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16,
    parameter int DECIM_W      = 8,
    parameter int POST_SAMPLES = 1024
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               sample_valid_i,
    input  logic [DATA_W-1:0]  sample_dat_i,
    input  logic               arm_i,
    input  logic               trig_i,
    input  logic               abort_i,
    input  logic [DECIM_W-1:0] decim_i,
    output logic               log_wb_cyc_o,
    output logic               log_wb_stb_o,
    output logic               log_wb_we_o,
    output logic [ADDR_W-1:0]  log_wb_adr_o,
    output logic [DATA_W-1:0]  log_wb_dat_o,
    input  logic               log_wb_ack_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               overflow_o,
    output logic [ADDR_W:0]    wr_count_o,
    output logic [ADDR_W-1:0]  trig_adr_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(2**ADDR_W - 1);

    if (POST_SAMPLES < 1 || POST_SAMPLES > 2**ADDR_W) begin : g_bad_post_samples
        $error("POST_SAMPLES must lie in 1..2**ADDR_W");
    end

    state_t             r_state;
    logic               r_cyc;
    logic [ADDR_W-1:0]  r_adr;
    logic [ADDR_W:0]    r_wr_count;
    logic               r_hold_valid;
    logic [DATA_W-1:0]  r_hold_dat;
    logic [DECIM_W-1:0] r_decim_cnt;
    logic               r_overflow;
`ifdef BIQUAD_LOG_PRETRIG_EN
    logic [ADDR_W-1:0]  r_trig_adr;
    logic [ADDR_W:0]    r_post_cnt;
    logic               r_pre_inflight;
`endif

    logic w_ack;
    logic w_wr_en;
    logic w_keep;
    logic w_arm_ok;
    logic w_last_ack;

    assign w_ack    = log_wb_ack_i & r_cyc;
    assign w_arm_ok = arm_i & ~r_cyc;
`ifdef BIQUAD_LOG_PRETRIG_EN
    assign w_wr_en    = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign w_last_ack = w_ack && (r_state == S_CAPTURE) && !r_pre_inflight
                        && (r_post_cnt == (ADDR_W+1)'(1));
`else
    assign w_wr_en    = (r_state == S_CAPTURE);
    assign w_last_ack = w_ack && (r_state == S_CAPTURE) && (r_wr_count == CNT_LAST);
`endif
    assign w_keep = sample_valid_i && w_wr_en && (r_decim_cnt == '0);

    // The hold register doubles as the bus data register: it stays full until the write is acked.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_cyc        <= 1'b0;
            r_adr        <= '0;
            r_wr_count   <= '0;
            r_hold_valid <= 1'b0;
            r_hold_dat   <= '0;
            r_decim_cnt  <= '0;
            r_overflow   <= 1'b0;
`ifdef BIQUAD_LOG_PRETRIG_EN
            r_trig_adr     <= '0;
            r_post_cnt     <= '0;
            r_pre_inflight <= 1'b0;
`endif
        end else begin
            if (w_ack) begin
                r_cyc        <= 1'b0;
                r_adr        <= r_adr + 1'b1;
                r_hold_valid <= 1'b0;
                if (r_wr_count != CNT_FULL)
                    r_wr_count <= r_wr_count + 1'b1;
            end else if (!r_cyc && r_hold_valid && w_wr_en && !abort_i && !w_arm_ok) begin
                r_cyc <= 1'b1;
            end

            if (sample_valid_i && w_wr_en)
                r_decim_cnt <= (r_decim_cnt == '0) ? decim_i : r_decim_cnt - 1'b1;

            if (w_keep) begin
                if (!r_hold_valid || w_ack) begin
                    r_hold_valid <= 1'b1;
                    r_hold_dat   <= sample_dat_i;
                end else begin
                    r_overflow <= 1'b1;
                end
            end

`ifdef BIQUAD_LOG_PRETRIG_EN
            // A write already on the bus at trigger time belongs to the pre-trigger history.
            if (w_ack && (r_state == S_CAPTURE)) begin
                if (r_pre_inflight)
                    r_pre_inflight <= 1'b0;
                else
                    r_post_cnt <= r_post_cnt - 1'b1;
            end
`endif

            if (abort_i) begin
                r_state      <= S_IDLE;
                r_hold_valid <= 1'b0;
            end else if (w_arm_ok) begin
                // A fresh capture keeps its first sample; decim_i applies from the next reload.
                r_state      <= S_ARMED;
                r_adr        <= '0;
                r_wr_count   <= '0;
                r_overflow   <= 1'b0;
                r_decim_cnt  <= '0;
                r_hold_valid <= 1'b0;
`ifdef BIQUAD_LOG_PRETRIG_EN
                r_trig_adr     <= '0;
                r_pre_inflight <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (trig_i) begin
                            r_state <= S_CAPTURE;
`ifdef BIQUAD_LOG_PRETRIG_EN
                            r_trig_adr     <= r_cyc ? r_adr + 1'b1 : r_adr;
                            r_post_cnt     <= (ADDR_W+1)'(POST_SAMPLES);
                            r_pre_inflight <= r_cyc && !w_ack;
`endif
                        end
                    end
                    S_CAPTURE: begin
                        if (w_last_ack) begin
                            r_state      <= S_DONE;
                            r_hold_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign log_wb_cyc_o = r_cyc;
    assign log_wb_stb_o = r_cyc;
    assign log_wb_we_o  = r_cyc;
    assign log_wb_adr_o = r_adr;
    assign log_wb_dat_o = r_hold_dat;
    assign busy_o       = (r_state == S_ARMED) || (r_state == S_CAPTURE) || r_cyc;
    assign done_o       = (r_state == S_DONE);
    assign overflow_o   = r_overflow;
    assign wr_count_o   = r_wr_count;
`ifdef BIQUAD_LOG_PRETRIG_EN
    assign trig_adr_o   = r_trig_adr;
`else
    assign trig_adr_o   = '0;
`endif

endmodule

// File: tb/tb_biquad_log_writer.sv
// Bench for biquad_log_writer: Wishbone slave model with configurable ack latency plus a sample-level
// reference model of decimation and capture order.
`timescale 1ns/1ps
module tb_biquad_log_writer;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_dat = '0;
    logic              arm = 1'b0, trig = 1'b0, abort = 1'b0;
    logic [7:0]        decim = '0;
    logic              cyc, stb, we, ack, busy, done, overflow;
    logic [ADDR_W-1:0] adr, trig_adr;
    logic [DATA_W-1:0] dat;
    logic [ADDR_W:0]   wr_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    biquad_log_writer dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sample_valid_i(sample_valid), .sample_dat_i(sample_dat),
        .arm_i(arm), .trig_i(trig), .abort_i(abort), .decim_i(decim),
        .log_wb_cyc_o(cyc), .log_wb_stb_o(stb), .log_wb_we_o(we), .log_wb_adr_o(adr),
        .log_wb_dat_o(dat), .log_wb_ack_i(ack), .busy_o(busy), .done_o(done),
        .overflow_o(overflow), .wr_count_o(wr_count), .trig_adr_o(trig_adr)
    );

    // Registered Wishbone slave: records every write it acks and flags protocol breaches.
    int                ack_lat = 1;
    int                wait_cnt = 0;
    int                viol = 0;
    logic              prev_stb = 1'b0, prev_ack = 1'b0;
    logic [ADDR_W-1:0] cur_adr = '0;
    logic [DATA_W-1:0] cur_dat = '0;
    logic [ADDR_W-1:0] wr_adr_q[$];
    logic [DATA_W-1:0] wr_dat_q[$];

    always @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0; wait_cnt <= 0; prev_stb <= 1'b0; prev_ack <= 1'b0;
        end else begin
            prev_stb <= stb;
            prev_ack <= ack;
            if ((we !== stb) || (cyc !== stb) || (prev_stb && !prev_ack && !stb) || (prev_ack && stb)
                || (prev_stb && !prev_ack && stb && ((adr !== cur_adr) || (dat !== cur_dat))))
                viol <= viol + 1;
            if (stb && !(prev_stb && !prev_ack)) begin
                cur_adr <= adr; cur_dat <= dat;
            end
            if (stb && !ack) begin
                if (wait_cnt >= ack_lat - 1) begin
                    ack <= 1'b1; wait_cnt <= 0;
                    wr_adr_q.push_back(adr); wr_dat_q.push_back(dat);
                end else wait_cnt <= wait_cnt + 1;
            end else ack <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; sample_valid = 1'b0; arm = 1'b0; trig = 1'b0; abort = 1'b0;
        tick(3); rst = 1'b0; tick(1);
    endtask

    task automatic clear_log();
        wr_adr_q.delete(); wr_dat_q.delete();
    endtask

    task automatic pulse_arm();   arm = 1'b1;   tick(1); arm = 1'b0;   endtask
    task automatic pulse_trig();  trig = 1'b1;  tick(1); trig = 1'b0;  endtask
    task automatic pulse_abort(); abort = 1'b1; tick(1); abort = 1'b0; tick(8); endtask

    task automatic send(input logic [DATA_W-1:0] d, input int gap);
        sample_valid = 1'b1; sample_dat = d; tick(1); sample_valid = 1'b0;
        if (gap > 1) tick(gap - 1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({cyc, stb, we, busy, done, overflow} !== 6'b0) begin failures++;
            $display("FAIL reset_flags got=%b exp=000000", {cyc, stb, we, busy, done, overflow}); end
        checks++; if (adr !== '0) begin failures++; $display("FAIL reset_adr got=%0d exp=0", adr); end
        checks++; if (dat !== '0) begin failures++; $display("FAIL reset_dat got=%0h exp=0", dat); end
        checks++; if (wr_count !== '0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        checks++; if (trig_adr !== '0) begin failures++; $display("FAIL reset_trig_adr got=%0d exp=0", trig_adr); end
    endtask

    task automatic test_full_capture();
        logic [DATA_W-1:0] exp_q[$];
        ack_lat = 1; decim = 8'd0; clear_log();
        pulse_arm(); pulse_trig();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(DATA_W'($urandom));
            send(exp_q[i], 4);
        end
        for (int i = 0; i < 50 && done !== 1'b1; i++) tick(1);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done); end
        checks++; if (wr_adr_q.size() !== DEPTH) begin failures++;
            $display("FAIL full_nwrites got=%0d exp=%0d", wr_adr_q.size(), DEPTH); end
        for (int i = 0; i < wr_adr_q.size() && i < DEPTH; i++) begin
            checks++;
            if (wr_adr_q[i] !== ADDR_W'(i) || wr_dat_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL full_write[%0d] got adr=%0d dat=%0h exp adr=%0d dat=%0h",
                         i, wr_adr_q[i], wr_dat_q[i], i, exp_q[i]);
                break;
            end
        end
        checks++; if (wr_count !== 12'd2048) begin failures++; $display("FAIL full_wr_count got=%0d exp=2048", wr_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy got=%b exp=0", busy); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL full_protocol got=%0d exp=0", viol); end
        send(16'hBEEF, 6);
        checks++; if (wr_adr_q.size() !== DEPTH) begin failures++;
            $display("FAIL done_no_write got=%0d exp=%0d", wr_adr_q.size(), DEPTH); end
    endtask

    // Reference: the first accepted sample is kept, then one in every decim+1.
    task automatic run_decim(input int d, input int n, input bit rnd, input string name);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] s;
        ack_lat = 1; decim = 8'(d); clear_log();
        pulse_arm(); pulse_trig();
        for (int i = 0; i < n; i++) begin
            s = rnd ? DATA_W'($urandom) : DATA_W'(i);
            if (i % (d + 1) == 0) exp_q.push_back(s);
            send(s, rnd ? int'($urandom_range(3, 6)) : 4);
        end
        tick(8);
        checks++; if (wr_adr_q.size() !== exp_q.size()) begin failures++;
            $display("FAIL %s_nwrites got=%0d exp=%0d", name, wr_adr_q.size(), exp_q.size()); end
        for (int i = 0; i < wr_adr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_adr_q[i] !== ADDR_W'(i) || wr_dat_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL %s_write[%0d] got adr=%0d dat=%0h exp adr=%0d dat=%0h",
                         name, i, wr_adr_q[i], wr_dat_q[i], i, exp_q[i]);
                break;
            end
        end
        checks++; if (wr_count !== (ADDR_W+1)'(exp_q.size())) begin failures++;
            $display("FAIL %s_wr_count got=%0d exp=%0d", name, wr_count, exp_q.size()); end
        pulse_abort();
    endtask

    task automatic test_decim();
        run_decim(3, 16, 1'b0, "decim3");
        run_decim(int'($urandom_range(1, 6)), 30, 1'b1, "decim_rnd");
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] smp_q[$];
        int j;
        bit ok;
        ack_lat = 1; decim = 8'd0; clear_log();
        pulse_arm(); pulse_trig();
        for (int i = 0; i < 20; i++) begin
            smp_q.push_back(DATA_W'($urandom));
            sample_valid = 1'b1; sample_dat = smp_q[i]; tick(1);
        end
        sample_valid = 1'b0; tick(8);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL ovf_protocol got=%0d exp=0", viol); end
        checks++; if (wr_adr_q.size() < 5) begin failures++; $display("FAIL ovf_nwrites got=%0d exp>=5", wr_adr_q.size()); end
        j = 0;
        for (int i = 0; i < wr_adr_q.size(); i++) begin
            ok = 1'b0;
            while (j < smp_q.size() && !ok) begin ok = (smp_q[j] === wr_dat_q[i]); j++; end
            checks++;
            if (!ok || wr_adr_q[i] !== ADDR_W'(i)) begin failures++;
                $display("FAIL ovf_write[%0d] got adr=%0d dat=%0h exp adr=%0d, dat in sample order",
                         i, wr_adr_q[i], wr_dat_q[i], i);
                break;
            end
        end
        pulse_abort();
        pulse_arm();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_arm_clear got=%b exp=0", overflow); end
        pulse_abort();
    endtask

    task automatic test_abort();
        ack_lat = 3; decim = 8'd0; clear_log();
        pulse_arm(); pulse_trig();
        send(16'h1234, 1);
        for (int i = 0; i < 10 && stb !== 1'b1; i++) tick(1);
        checks++; if (stb !== 1'b1) begin failures++; $display("FAIL abort_stb_start got=%b exp=1", stb); end
        abort = 1'b1; tick(1); abort = 1'b0;
        checks++; if ({stb, busy} !== 2'b11) begin failures++;
            $display("FAIL abort_held got stb,busy=%b exp=11", {stb, busy}); end
        for (int i = 0; i < 20 && stb !== 1'b0; i++) tick(1);
        checks++; if (wr_adr_q.size() !== 1 || wr_dat_q[0] !== 16'h1234) begin failures++;
            $display("FAIL abort_write got n=%0d exp n=1 dat=1234", wr_adr_q.size()); end
        tick(2);
        checks++; if ({busy, done, cyc} !== 3'b000) begin failures++;
            $display("FAIL abort_idle got busy,done,cyc=%b exp=000", {busy, done, cyc}); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL abort_protocol got=%0d exp=0", viol); end
        send(16'h5678, 8);
        checks++; if (wr_adr_q.size() !== 1) begin failures++;
            $display("FAIL abort_ignores_samples got=%0d exp=1", wr_adr_q.size()); end
    endtask

    task automatic test_arm_trig_same();
        logic [DATA_W-1:0] exp_q[$];
        ack_lat = 1; decim = 8'd0; clear_log();
        arm = 1'b1; trig = 1'b1; tick(1); arm = 1'b0; trig = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin failures++;
            $display("FAIL armtrig_armed got busy,done=%b exp=10", {busy, done}); end
        for (int i = 0; i < 5; i++) send(DATA_W'($urandom), 4);
        tick(4);
        checks++; if (wr_adr_q.size() !== 0) begin failures++;
            $display("FAIL armtrig_no_writes got=%0d exp=0", wr_adr_q.size()); end
        pulse_trig();
        for (int i = 0; i < 3; i++) begin exp_q.push_back(DATA_W'($urandom)); send(exp_q[i], 4); end
        tick(6);
        checks++; if (wr_adr_q.size() !== 3) begin failures++;
            $display("FAIL armtrig_nwrites got=%0d exp=3", wr_adr_q.size()); end
        for (int i = 0; i < wr_adr_q.size() && i < 3; i++) begin
            checks++;
            if (wr_adr_q[i] !== ADDR_W'(i) || wr_dat_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL armtrig_write[%0d] got adr=%0d dat=%0h exp adr=%0d dat=%0h",
                         i, wr_adr_q[i], wr_dat_q[i], i, exp_q[i]);
            end
        end
        pulse_abort();
    endtask

    task automatic test_reset_midcycle();
        ack_lat = 3; decim = 8'd0; clear_log();
        pulse_arm(); pulse_trig();
        send(16'hA5A5, 1);
        for (int i = 0; i < 10 && stb !== 1'b1; i++) tick(1);
        rst = 1'b1; tick(1);
        checks++; if ({cyc, stb, busy} !== 3'b000 || wr_count !== '0) begin failures++;
            $display("FAIL rst_mid got cyc,stb,busy=%b cnt=%0d exp=000 cnt=0", {cyc, stb, busy}, wr_count); end
        rst = 1'b0; tick(2);
    endtask

`ifdef BIQUAD_LOG_PRETRIG_EN
    task automatic test_pretrig();
        logic [DATA_W-1:0] post_q[$];
        int npost;
        ack_lat = 1; decim = 8'd0; clear_log();
        pulse_arm();
        for (int i = 0; i < 2500; i++) send(DATA_W'($urandom), 4);
        tick(6);
        checks++; if (wr_adr_q.size() !== 2500) begin failures++;
            $display("FAIL pre_nwrites got=%0d exp=2500", wr_adr_q.size()); end
        pulse_trig();
        checks++; if (trig_adr !== 11'd452) begin failures++; $display("FAIL pre_trig_adr got=%0d exp=452", trig_adr); end
        for (int i = 0; i < 1100 && done !== 1'b1; i++) begin
            post_q.push_back(DATA_W'($urandom)); send(post_q[i], 4);
        end
        tick(6);
        npost = wr_adr_q.size() - 2500;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL pre_done got=%b exp=1", done); end
        checks++; if (npost !== 1024) begin failures++; $display("FAIL pre_npost got=%0d exp=1024", npost); end
        checks++; if (wr_adr_q[wr_adr_q.size()-1] !== 11'd1475) begin failures++;
            $display("FAIL pre_last_adr got=%0d exp=1475", wr_adr_q[wr_adr_q.size()-1]); end
        for (int i = 0; i < npost && i < post_q.size(); i++) begin
            checks++;
            if (wr_adr_q[2500+i] !== ADDR_W'(452 + i) || wr_dat_q[2500+i] !== post_q[i]) begin failures++;
                $display("FAIL pre_post_write[%0d] got adr=%0d dat=%0h exp adr=%0d dat=%0h",
                         i, wr_adr_q[2500+i], wr_dat_q[2500+i], 452 + i, post_q[i]);
                break;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef BIQUAD_LOG_PRETRIG_EN
        test_pretrig();
`else
        test_full_capture();
        test_decim();
        test_overflow();
        test_abort();
        test_arm_trig_same();
        test_reset_midcycle();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
